vbs_raster_gen: RTL and testbench

VBS_RASTER_GEN -- requirements
Module: vbs_raster_gen

---
 rtl/vbs_pkg.sv | 32 +++
 rtl/vbs_timing.sv | 85 ++++++++
 rtl/vbs_raster_gen.sv | 159 +++++++++++++++
 tb/tb_vbs_raster_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vbs_pkg
//  Description : Shared timing constants (PAL and NTSC) for the video
//                raster generator, plus a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vbs_pkg;

  // PAL: 64 us lines at 4 MHz, 313 lines per field
  localparam int unsigned C_PAL_H_TOTAL     = 256;
  localparam int unsigned C_PAL_V_TOTAL     = 313;
  localparam int unsigned C_PAL_HSYNC_W     = 14;
  localparam int unsigned C_PAL_VSYNC_LINES = 3;
  localparam int unsigned C_PAL_X_START     = 48;
  localparam int unsigned C_PAL_Y_START     = 35;

  // NTSC: 262 lines per field
  localparam int unsigned C_NTSC_H_TOTAL     = 254;
  localparam int unsigned C_NTSC_V_TOTAL     = 262;
  localparam int unsigned C_NTSC_HSYNC_W     = 14;
  localparam int unsigned C_NTSC_VSYNC_LINES = 3;
  localparam int unsigned C_NTSC_X_START     = 48;
  localparam int unsigned C_NTSC_Y_START     = 20;

  // Width of a counter holding 0..n-1, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vbs_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vbs_timing
//  Description : Free-running h/v raster counters with registered composite
//                sync, vertical blanking and frame-start outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vbs_timing
  import vbs_pkg::*;
#(
  parameter int unsigned H_TOTAL     = C_PAL_H_TOTAL,
  parameter int unsigned V_TOTAL     = C_PAL_V_TOTAL,
  parameter int unsigned HSYNC_W     = C_PAL_HSYNC_W,
  parameter int unsigned VSYNC_LINES = C_PAL_VSYNC_LINES,
  parameter int unsigned X_START     = C_PAL_X_START,
  parameter int unsigned Y_START     = C_PAL_Y_START,
  parameter int unsigned ACT_W       = 128,
  parameter int unsigned ACT_H       = 256,
  parameter int unsigned HW          = 8,
  parameter int unsigned VW          = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          h_active_o,
  output logic          v_active_o,
  output logic          sync_next_o,
  output logic          sync_o,
  output logic          vblank_o,
  output logic          frame_start_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          sync_q, vblank_q, fs_q;
  int unsigned   w_h, w_v;
  logic          w_sync_lvl, w_v_active, w_h_active;

  // Counter advance, sync shape (broad pulses on the first lines) and windows
  always_comb begin
    w_h = 32'(h_q);
    w_v = 32'(v_q);
    h_d = (w_h == H_TOTAL - 1) ? '0 : h_q + HW'(1);
    v_d = v_q;
    if (w_h == H_TOTAL - 1) begin
      v_d = (w_v == V_TOTAL - 1) ? '0 : v_q + VW'(1);
    end
    if (w_v < VSYNC_LINES) begin
      w_sync_lvl = !((w_h >= 1) && (w_h < H_TOTAL - HSYNC_W));
    end else begin
      w_sync_lvl = !((w_h >= 1) && (w_h < 1 + HSYNC_W));
    end
    w_v_active = (w_v >= Y_START) && (w_v < Y_START + ACT_H);
    w_h_active = (w_h >= X_START) && (w_h < X_START + ACT_W);
  end

  // Counters and registered timing outputs (one cycle behind h/v)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= '0;
      v_q      <= '0;
      sync_q   <= 1'b1;
      vblank_q <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      sync_q   <= w_sync_lvl;
      vblank_q <= !w_v_active;
      fs_q     <= (h_q == '0) && (v_q == '0);
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign h_active_o    = w_h_active;
  assign v_active_o    = w_v_active;
  assign sync_next_o   = w_sync_lvl;
  assign sync_o        = sync_q;
  assign vblank_o      = vblank_q;
  assign frame_start_o = fs_q;

endmodule
`default_nettype wire

// File: rtl/vbs_raster_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vbs_raster_gen
//  Description : 1-bpp bitmap raster generator: byte fetch two clocks ahead,
//                holding register, MSB-first shifter and pixel/border/sync mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module vbs_raster_gen
  import vbs_pkg::*;
#(
  parameter int unsigned H_TOTAL       = C_PAL_H_TOTAL,
  parameter int unsigned V_TOTAL       = C_PAL_V_TOTAL,
  parameter int unsigned HSYNC_W       = C_PAL_HSYNC_W,
  parameter int unsigned VSYNC_LINES   = C_PAL_VSYNC_LINES,
  parameter int unsigned X_START       = C_PAL_X_START,
  parameter int unsigned Y_START       = C_PAL_Y_START,
  parameter int unsigned BYTES_PER_ROW = 16,
  parameter int unsigned ROWS          = 128,
  parameter int unsigned LINE_REPEAT   = 2,
  parameter int unsigned ADDR_W        = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              invert,
  input  logic              border,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              sync,
  output logic              pixel,
  output logic              vblank,
  output logic              frame_start
);

  localparam int unsigned C_ACT_W    = 8 * BYTES_PER_ROW;
  localparam int unsigned C_ACT_H    = ROWS * LINE_REPEAT;
  localparam int unsigned C_HW       = clog2_min1(H_TOTAL);
  localparam int unsigned C_VW       = clog2_min1(V_TOTAL);
  localparam int unsigned C_RW       = clog2_min1(ROWS + 1);
  localparam int          C_FETCH_H0 = int'(X_START) - 2;

  // Elaboration-time parameter legality
  if (X_START < 2) begin : g_chk_xstart
    $error("vbs_raster_gen: X_START must be >= 2");
  end
  if (X_START + C_ACT_W > H_TOTAL) begin : g_chk_width
    $error("vbs_raster_gen: active width exceeds H_TOTAL");
  end
  if (Y_START + C_ACT_H > V_TOTAL) begin : g_chk_height
    $error("vbs_raster_gen: active height exceeds V_TOTAL");
  end
  if (ROWS * BYTES_PER_ROW > (2 ** ADDR_W)) begin : g_chk_addr
    $error("vbs_raster_gen: bitmap does not fit in ADDR_W");
  end
  if (Y_START < VSYNC_LINES) begin : g_chk_ystart
    $error("vbs_raster_gen: Y_START must be >= VSYNC_LINES");
  end
  if ((LINE_REPEAT < 1) || (LINE_REPEAT > 4)) begin : g_chk_repeat
    $error("vbs_raster_gen: LINE_REPEAT must be 1..4");
  end

  logic [C_HW-1:0] w_h;
  logic [C_VW-1:0] w_v;
  logic            w_h_active, w_v_active, w_sync_next;

  vbs_timing #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HSYNC_W(HSYNC_W),
    .VSYNC_LINES(VSYNC_LINES), .X_START(X_START), .Y_START(Y_START),
    .ACT_W(C_ACT_W), .ACT_H(C_ACT_H), .HW(C_HW), .VW(C_VW)
  ) u_timing (
    .clk          (clk),
    .reset_n      (reset_n),
    .h_o          (w_h),
    .v_o          (w_v),
    .h_active_o   (w_h_active),
    .v_active_o   (w_v_active),
    .sync_next_o  (w_sync_next),
    .sync_o       (sync),
    .vblank_o     (vblank),
    .frame_start_o(frame_start)
  );

  logic [C_RW-1:0] row_q, row_d;
  logic [1:0]      rep_q, rep_d;
  logic            inv_q, rd_pend_q, pixel_q, pixel_d;
  logic [7:0]      hold_q, shift_q, shift_d, w_cur;
  int              w_fd, w_px;
  int unsigned     w_addr;
  logic            w_fetch, w_load, w_in_win, w_line_end;

  // Fetch timing, shifter feed and pixel mux for the current (h,v)
  always_comb begin
    w_fd     = int'(w_h) - C_FETCH_H0;
    w_px     = int'(w_h) - int'(X_START);
    w_fetch  = w_v_active && (w_fd >= 0) && (w_fd < int'(C_ACT_W)) && ((w_fd % 8) == 0);
    w_addr   = 32'(row_q) * BYTES_PER_ROW + 32'(w_fd >>> 3);
    w_in_win = w_v_active && w_h_active;
    // Byte boundary: the held byte enters the shifter and its MSB is shown now
    w_load   = w_in_win && ((w_px % 8) == 0);
    w_cur    = w_load ? hold_q : shift_q;
    shift_d  = {w_cur[6:0], 1'b0};
    if (!w_sync_next) begin
      pixel_d = 1'b0;
    end else if (w_in_win) begin
      pixel_d = w_cur[7] ^ inv_q;
    end else begin
      pixel_d = border;
    end
  end

  // Bitmap row tracking: advance every LINE_REPEAT lines, clear outside window
  always_comb begin
    row_d      = row_q;
    rep_d      = rep_q;
    w_line_end = (32'(w_h) == H_TOTAL - 1);
    if (w_line_end) begin
      if (!w_v_active || (32'(w_v) == V_TOTAL - 1)) begin
        row_d = '0;
        rep_d = '0;
      end else if (32'(rep_q) == LINE_REPEAT - 1) begin
        rep_d = '0;
        row_d = row_q + C_RW'(1);
      end else begin
        rep_d = rep_q + 2'd1;
      end
    end
  end

  // Datapath registers; reset discards any read still in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      rep_q     <= '0;
      inv_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
      shift_q   <= '0;
      pixel_q   <= 1'b0;
    end else begin
      row_q     <= row_d;
      rep_q     <= rep_d;
      rd_pend_q <= w_fetch;
      shift_q   <= shift_d;
      pixel_q   <= pixel_d;
      if (w_h == '0) begin
        inv_q <= invert;
      end
      if (rd_pend_q) begin
        hold_q <= mem_data;
      end
    end
  end

  assign mem_rd   = w_fetch;
  assign mem_addr = w_fetch ? ADDR_W'(w_addr) : '0;
  assign pixel    = pixel_q;

endmodule
`default_nettype wire

// File: tb/tb_vbs_raster_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vbs_raster_gen
//  Description : Self-checking bench for vbs_raster_gen with random memory,
//                random border/invert and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vbs_raster_gen;

  localparam int H = 256, V = 313, XS = 48, YS = 35, BPR = 16, ROWS = 128, LR = 2;
  localparam int C_RST_POS = 40 * H + 60;
  localparam int C_RUN2    = H * V + 80;

  logic        clk = 1'b0, reset_n = 1'b0, invert = 1'b0, border = 1'b0;
  logic        mem_rd, sync, pixel, vblank, frame_start;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_rd2, sync2, pixel2, vblank2, frame_start2;
  logic [11:0] mem_addr2;
  logic [7:0]  mem_data2 = 8'h00;
  logic [7:0]  mem [0:2047];

  int checks = 0, failures = 0;
  bit line_inv = 1'b0;
  int fs_first = -1, fs_second = -1, slc0 = 0, slc5 = 0;
  int rd_first_h = -1, rd_first_v = -1, rd_first_a = -1, rd36 = 0;
  int n290 = 0, n291 = 0, a290_first = -1, a290_last = -1;

  always #5 clk = ~clk;

  vbs_raster_gen dut (
    .clk(clk), .reset_n(reset_n), .invert(invert), .border(border),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .sync(sync), .pixel(pixel), .vblank(vblank), .frame_start(frame_start)
  );

  vbs_raster_gen #(.ROWS(256), .LINE_REPEAT(1), .ADDR_W(12)) dut2 (
    .clk(clk), .reset_n(reset_n), .invert(invert), .border(border),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .sync(sync2), .pixel(pixel2), .vblank(vblank2), .frame_start(frame_start2)
  );

  // Synchronous memory: data one cycle after the strobe, noise otherwise
  always @(posedge clk) begin
    mem_data  <= mem_rd ? mem[mem_addr] : 8'($urandom);
    mem_data2 <= 8'($urandom);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_sync(input int h, input int v);
    if (v < 3) return (h >= 1 && h < H - 14) ? 0 : 1;
    return (h >= 1 && h < 1 + 14) ? 0 : 1;
  endfunction

  function automatic int exp_pixel(input int h, input int v, input int brd, input int inv);
    int x;
    logic [7:0] b;
    if (exp_sync(h, v) == 0) return 0;
    if (v >= YS && v < YS + ROWS * LR && h >= XS && h < XS + 8 * BPR) begin
      x = h - XS;
      b = mem[((v - YS) / LR) * BPR + x / 8];
      return int'(b[7 - x % 8]) ^ inv;
    end
    return brd;
  endfunction

  function automatic bit fetch_col(input int h);
    return (h >= XS - 2) && (h < XS - 2 + 8 * BPR) && ((h - (XS - 2)) % 8 == 0);
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_sync"}, sync, 1);
    check_eq({tag, "_pixel"}, pixel, 0);
    check_eq({tag, "_mem_rd"}, mem_rd, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_vblank"}, vblank, 1);
    check_eq({tag, "_frame_start"}, frame_start, 0);
  endtask

  // One sample, taken on the falling edge after k rising edges since reset release
  task automatic sample(input int k, input bit ph2);
    int p, hp, vp, d, hd, vd, e_rd, e_rd2;
    p  = k % (H * V);
    hp = p % H;
    vp = p / H;
    e_rd  = (vp >= YS && vp < YS + ROWS * LR && fetch_col(hp)) ? 1 : 0;
    e_rd2 = (vp >= YS && vp < YS + 256 && fetch_col(hp)) ? 1 : 0;
    check_eq("mem_rd", mem_rd, e_rd);
    if (e_rd != 0) check_eq("mem_addr", mem_addr, ((vp - YS) / LR) * BPR + (hp - XS + 2) / 8);
    check_eq("mem_rd2", mem_rd2, e_rd2);
    if (e_rd2 != 0) check_eq("mem_addr2", mem_addr2, (vp - YS) * BPR + (hp - XS + 2) / 8);
    if (k == 0) begin
      check_reset("rst_release");
    end else begin
      d  = (k - 1) % (H * V);
      hd = d % H;
      vd = d / H;
      check_eq("sync", sync, exp_sync(hd, vd));
      check_eq("vblank", vblank, (vd >= YS && vd < YS + ROWS * LR) ? 0 : 1);
      check_eq("frame_start", frame_start, (d == 0) ? 1 : 0);
      check_eq("pixel", pixel, exp_pixel(hd, vd, border, line_inv));
      if (ph2 && (k - 1) < H * V && !sync) begin
        if (vd == 0) slc0++;
        if (vd == 5) slc5++;
      end
    end
    if (ph2) begin
      if (frame_start) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (mem_rd && rd_first_h < 0) begin
        rd_first_h = hp; rd_first_v = vp; rd_first_a = mem_addr;
      end
      if (mem_rd && vp == 36 && k < H * V) rd36++;
      if (mem_rd2 && k < H * V) begin
        if (vp == 290) begin
          n290++;
          if (a290_first < 0) a290_first = mem_addr2;
          a290_last = mem_addr2;
        end
        if (vp == 291) n291++;
      end
    end
    // New inputs for this cycle; invert is latched by the DUT at h=0
    if ($urandom_range(15) == 0) border = ~border;
    if ($urandom_range(127) == 0) invert = ~invert;
    if (hp == 0) line_inv = invert;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    for (int k = 0; k <= C_RST_POS; k++) begin
      if (k > 0) @(negedge clk);
      sample(k, 1'b0);
    end
    // Asynchronous reset in the middle of an active, fetching line
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset("async");
    repeat (3) begin
      @(negedge clk);
      check_reset("hold");
    end
    reset_n = 1'b1;
    for (int k = 0; k < C_RUN2; k++) begin
      if (k > 0) @(negedge clk);
      sample(k, 1'b1);
    end
    check_eq("fs_first_cycle", fs_first, 1);
    check_eq("frame_period", fs_second - fs_first, H * V);
    check_eq("sync_low_line0", slc0, 241);
    check_eq("sync_low_line5", slc5, 14);
    check_eq("first_rd_h", rd_first_h, 46);
    check_eq("first_rd_v", rd_first_v, 35);
    check_eq("first_rd_addr", rd_first_a, 0);
    check_eq("reads_line36", rd36, 16);
    check_eq("dut2_reads_v290", n290, 16);
    check_eq("dut2_first_addr_v290", a290_first, 4080);
    check_eq("dut2_last_addr_v290", a290_last, 4095);
    check_eq("dut2_reads_v291", n291, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
